// File: rtl/async_filter_pkg.sv
// Shared constants for the board input synchroniser bank.
// Holds the synchroniser depth limits, the default debounce count, the board
// channel map, and the board-level reset-value / filter-enable vectors built
// from that map. These vectors are meant for the board top-level
// instantiation; the bank's own parameter defaults are all-zero masks.
package async_filter_pkg;

  localparam int unsigned SYNC_STAGES_MIN  = 2;
  localparam int unsigned SYNC_STAGES_MAX  = 4;
  localparam int unsigned FILT_CNT_DEFAULT = 32;
  localparam int unsigned NUM_CH_DEFAULT   = 24;

  // Board channel indices
  localparam int unsigned CH_RST_BUTTON      = 0;
  localparam int unsigned CH_POWER_BUTTON    = 1;
  localparam int unsigned CH_ATX_PG          = 2;
  localparam int unsigned CH_S0_VTT_PWRGD    = 3;
  localparam int unsigned CH_S0_VDDCR_PG     = 4;
  localparam int unsigned CH_S0_VDDIO_PG     = 5;
  localparam int unsigned CH_S0_MEM_ABCD_PG  = 6;
  localparam int unsigned CH_S0_MEM_EFGH_PG  = 7;
  localparam int unsigned CH_S1_VTT_PWRGD    = 8;
  localparam int unsigned CH_S1_VDDCR_PG     = 9;
  localparam int unsigned CH_S1_VDDIO_PG     = 10;
  localparam int unsigned CH_S1_MEM_ABCD_PG  = 11;
  localparam int unsigned CH_S1_MEM_EFGH_PG  = 12;
  localparam int unsigned CH_BMC_PWR_REQ_N   = 13;
  localparam int unsigned CH_BMC_RST_REQ_N   = 14;
  localparam int unsigned CH_BMC_READY       = 15;
  localparam int unsigned CH_FAN_FAIL_N      = 16;
  localparam int unsigned CH_PSU0_ALERT_N    = 17;
  localparam int unsigned CH_PSU1_ALERT_N    = 18;
  localparam int unsigned CH_S0_THERMTRIP_N  = 19;
  localparam int unsigned CH_S1_THERMTRIP_N  = 20;
  localparam int unsigned CH_S0_PROCHOT_N    = 21;
  localparam int unsigned CH_S0_TS_ALARM     = 22;
  localparam int unsigned CH_S1_TS_ALARM     = 23;

  function automatic logic [NUM_CH_DEFAULT-1:0] ch_bit(input int unsigned idx);
    ch_bit = NUM_CH_DEFAULT'(1) << idx;
  endfunction

  // Active-low board signals idle high, so they reset to 1 to avoid a
  // spurious "asserted" view straight out of reset.
  localparam logic [NUM_CH_DEFAULT-1:0] BOARD_RST_VAL =
      ch_bit(CH_RST_BUTTON)     | ch_bit(CH_POWER_BUTTON)   |
      ch_bit(CH_BMC_PWR_REQ_N)  | ch_bit(CH_BMC_RST_REQ_N)  |
      ch_bit(CH_FAN_FAIL_N)     | ch_bit(CH_PSU0_ALERT_N)   |
      ch_bit(CH_PSU1_ALERT_N)   | ch_bit(CH_S0_THERMTRIP_N) |
      ch_bit(CH_S1_THERMTRIP_N) | ch_bit(CH_S0_PROCHOT_N);

  // Mechanical buttons bounce; the fan tach alarm chatters near threshold.
  localparam logic [NUM_CH_DEFAULT-1:0] BOARD_FILT_EN =
      ch_bit(CH_RST_BUTTON) | ch_bit(CH_POWER_BUTTON) | ch_bit(CH_FAN_FAIL_N);

endpackage

// File: rtl/async_filter_ch.sv
// One channel of the input bank: synchroniser, optional debounce counter,
// level register and registered rise/fall pulses.
// Ports:
//   i_clk_32k   system clock
//   i_rst       synchronous active-high reset
//   i_async     raw asynchronous input
//   i_hold      freeze level, clear counter, suppress pulses
//   o_level     synchronised / filtered level
//   o_rise      one-cycle pulse on level 0->1
//   o_fall      one-cycle pulse on level 1->0
//   o_change_d  next-cycle value of (o_rise | o_fall), for the bank-wide OR register
module async_filter_ch
  import async_filter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned FILT_CNT    = FILT_CNT_DEFAULT,
  parameter bit          FILT_EN     = 1'b0,
  parameter bit          RST_VAL     = 1'b0
) (
  input  logic i_clk_32k,
  input  logic i_rst,
  input  logic i_async,
  input  logic i_hold,
  output logic o_level,
  output logic o_rise,
  output logic o_fall,
  output logic o_change_d
);

  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("async_filter_ch: SYNC_STAGES out of range");
  end

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(FILT_CNT - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic [CNT_W-1:0]       w_cnt_d;
  logic                   r_level;
  logic                   w_level_d;
  logic                   r_rise;
  logic                   r_fall;
  logic                   w_rise_d;
  logic                   w_fall_d;
  logic                   w_sync;

  assign w_sync = r_sync[SYNC_STAGES-1];

  always_comb begin
    w_level_d = r_level;
    w_cnt_d   = '0;
    if (!i_hold) begin
      if (!FILT_EN) begin
        w_level_d = w_sync;
      end else if (w_sync != r_level) begin
        // Counter saturates at CntLast: that sample commits the new level.
        if (r_cnt == CntLast) begin
          w_level_d = w_sync;
        end else begin
          w_cnt_d = r_cnt + CNT_W'(1);
        end
      end
    end
    // Hold forces w_level_d == r_level, so pulses vanish without a separate gate.
    w_rise_d = w_level_d & ~r_level;
    w_fall_d = ~w_level_d & r_level;
  end

  always_ff @(posedge i_clk_32k) begin
    if (i_rst) begin
      r_sync  <= {SYNC_STAGES{RST_VAL}};
      r_level <= RST_VAL;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      // The synchroniser keeps shifting during hold.
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_level <= w_level_d;
      r_cnt   <= w_cnt_d;
      r_rise  <= w_rise_d;
      r_fall  <= w_fall_d;
    end
  end

  assign o_level    = r_level;
  assign o_rise     = r_rise;
  assign o_fall     = r_fall;
  assign o_change_d = w_rise_d | w_fall_d;

endmodule

// File: rtl/async_filter_bank.sv
// Bank of NUM_CH asynchronous board inputs brought into the 32 kHz domain,
// each with its own synchroniser, optional debounce and edge pulses.
// Ports:
//   i_clk_32k     system clock (only clock)
//   i_rst         synchronous active-high reset
//   i_async       raw asynchronous inputs
//   i_hold        freeze levels, clear counters, suppress pulses
//   o_level       synchronised (and filtered where enabled) levels
//   o_rise        one-cycle pulses on level 0->1
//   o_fall        one-cycle pulses on level 1->0
//   o_any_change  registered OR of all pulses, aligned with them
module async_filter_bank
  import async_filter_pkg::*;
#(
  parameter int unsigned       NUM_CH      = NUM_CH_DEFAULT,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       CNT_W       = 8,
  parameter int unsigned       FILT_CNT    = FILT_CNT_DEFAULT,
  parameter logic [NUM_CH-1:0] FILT_EN     = {NUM_CH{1'b0}},
  parameter logic [NUM_CH-1:0] RST_VAL     = {NUM_CH{1'b0}}
) (
  input  logic              i_clk_32k,
  input  logic              i_rst,
  input  logic [NUM_CH-1:0] i_async,
  input  logic              i_hold,
  output logic [NUM_CH-1:0] o_level,
  output logic [NUM_CH-1:0] o_rise,
  output logic [NUM_CH-1:0] o_fall,
  output logic              o_any_change
);

  if (NUM_CH < 1 || NUM_CH > 64) begin : g_bad_num_ch
    $error("async_filter_bank: NUM_CH out of range");
  end
  if (FILT_CNT < 1 || FILT_CNT > (2 ** CNT_W) - 1) begin : g_bad_filt_cnt
    $error("async_filter_bank: FILT_CNT out of range for CNT_W");
  end

  logic [NUM_CH-1:0] w_change_d;
  logic              r_any_change;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    async_filter_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .FILT_CNT    (FILT_CNT),
      .FILT_EN     (FILT_EN[g]),
      .RST_VAL     (RST_VAL[g])
    ) u_ch (
      .i_clk_32k  (i_clk_32k),
      .i_rst      (i_rst),
      .i_async    (i_async[g]),
      .i_hold     (i_hold),
      .o_level    (o_level[g]),
      .o_rise     (o_rise[g]),
      .o_fall     (o_fall[g]),
      .o_change_d (w_change_d[g])
    );
  end

  // Registered from the channels' next-state pulses so it lines up with o_rise/o_fall.
  always_ff @(posedge i_clk_32k) begin
    if (i_rst) begin
      r_any_change <= 1'b0;
    end else begin
      r_any_change <= |w_change_d;
    end
  end

  assign o_any_change = r_any_change;

endmodule

// File: tb/tb_async_filter_bank.sv
module tb_async_filter_bank;

  logic       clk;
  logic       rst;
  logic [3:0] async_in;
  logic       hold;
  logic [3:0] level;
  logic [3:0] rise;
  logic [3:0] fall;
  logic       any_change;

  int n_checks = 0;
  int n_errors = 0;

  async_filter_bank #(
    .NUM_CH      (4),
    .SYNC_STAGES (2),
    .CNT_W       (8),
    .FILT_CNT    (4),
    .FILT_EN     (4'b1100),
    .RST_VAL     (4'b0101)
  ) dut (
    .i_clk_32k    (clk),
    .i_rst        (rst),
    .i_async      (async_in),
    .i_hold       (hold),
    .o_level      (level),
    .o_rise       (rise),
    .o_fall       (fall),
    .o_any_change (any_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one clock, then check all outputs against hand-computed values.
  task automatic step(input string tag, input logic [3:0] lv, input logic [3:0] rs,
                      input logic [3:0] fl, input logic an);
    tick();
    chk({tag, ".level"}, level, lv);
    chk({tag, ".rise"}, rise, rs);
    chk({tag, ".fall"}, fall, fl);
    chk({tag, ".any"}, {3'b000, any_change}, {3'b000, an});
  endtask

  initial begin
    rst      = 1'b1;
    hold     = 1'b0;
    async_in = 4'b1010;

    // 1. Reset with inputs opposite to RST_VAL
    step("rst0", 4'b0101, 4'b0000, 4'b0000, 1'b0);
    step("rst1", 4'b0101, 4'b0000, 4'b0000, 1'b0);
    step("rst2", 4'b0101, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    step("rel1", 4'b0101, 4'b0000, 4'b0000, 1'b0);
    step("rel2", 4'b0101, 4'b0000, 4'b0000, 1'b0);
    step("rel3", 4'b0110, 4'b0010, 4'b0001, 1'b1);
    step("rel4", 4'b0110, 4'b0000, 4'b0000, 1'b0);
    step("rel5", 4'b0110, 4'b0000, 4'b0000, 1'b0);
    step("rel6", 4'b1010, 4'b1000, 4'b0100, 1'b1);
    step("rel7", 4'b1010, 4'b0000, 4'b0000, 1'b0);

    // 2. Unfiltered latency on ch1: drop it, then step 0->1
    async_in = 4'b1000;
    step("unf_dn1", 4'b1010, 4'b0000, 4'b0000, 1'b0);
    step("unf_dn2", 4'b1010, 4'b0000, 4'b0000, 1'b0);
    step("unf_dn3", 4'b1000, 4'b0000, 4'b0010, 1'b1);
    step("unf_dn4", 4'b1000, 4'b0000, 4'b0000, 1'b0);
    async_in = 4'b1010;
    step("unf_up1", 4'b1000, 4'b0000, 4'b0000, 1'b0);
    step("unf_up2", 4'b1000, 4'b0000, 4'b0000, 1'b0);
    step("unf_up3", 4'b1010, 4'b0010, 4'b0000, 1'b1);
    step("unf_up4", 4'b1010, 4'b0000, 4'b0000, 1'b0);

    // 3. Filtered clean steps on ch3: 6-clock latency
    async_in = 4'b0010;
    for (int i = 1; i <= 5; i++) step("flt_dn_wait", 4'b1010, 4'b0000, 4'b0000, 1'b0);
    step("flt_dn6", 4'b0010, 4'b0000, 4'b1000, 1'b1);
    step("flt_dn7", 4'b0010, 4'b0000, 4'b0000, 1'b0);
    async_in = 4'b1010;
    for (int i = 1; i <= 5; i++) step("flt_up_wait", 4'b0010, 4'b0000, 4'b0000, 1'b0);
    step("flt_up6", 4'b1010, 4'b1000, 4'b0000, 1'b1);
    step("flt_up7", 4'b1010, 4'b0000, 4'b0000, 1'b0);

    // 4. Glitch rejection on ch2: bring it high first
    async_in = 4'b1110;
    for (int i = 1; i <= 5; i++) step("g_pre_wait", 4'b1010, 4'b0000, 4'b0000, 1'b0);
    step("g_pre6", 4'b1110, 4'b0100, 4'b0000, 1'b1);
    step("g_pre7", 4'b1110, 4'b0000, 4'b0000, 1'b0);
    // 3 low samples: must be swallowed
    async_in = 4'b1010;
    for (int i = 1; i <= 3; i++) step("g3_low", 4'b1110, 4'b0000, 4'b0000, 1'b0);
    async_in = 4'b1110;
    for (int i = 1; i <= 6; i++) step("g3_after", 4'b1110, 4'b0000, 4'b0000, 1'b0);
    // 4 low samples: propagates once, then the restored high comes back
    async_in = 4'b1010;
    for (int i = 1; i <= 4; i++) step("g4_low", 4'b1110, 4'b0000, 4'b0000, 1'b0);
    async_in = 4'b1110;
    step("g4_e5", 4'b1110, 4'b0000, 4'b0000, 1'b0);
    step("g4_e6", 4'b1010, 4'b0000, 4'b0100, 1'b1);
    for (int i = 7; i <= 9; i++) step("g4_back", 4'b1010, 4'b0000, 4'b0000, 1'b0);
    step("g4_e10", 4'b1110, 4'b0100, 4'b0000, 1'b1);
    step("g4_e11", 4'b1110, 4'b0000, 4'b0000, 1'b0);

    // 5. Hold: step ch1 and ch3 low while frozen
    hold     = 1'b1;
    async_in = 4'b0100;
    for (int i = 1; i <= 10; i++) step("hold", 4'b1110, 4'b0000, 4'b0000, 1'b0);
    hold = 1'b0;
    step("unhold1", 4'b1100, 4'b0000, 4'b0010, 1'b1);
    step("unhold2", 4'b1100, 4'b0000, 4'b0000, 1'b0);
    step("unhold3", 4'b1100, 4'b0000, 4'b0000, 1'b0);
    step("unhold4", 4'b0100, 4'b0000, 4'b1000, 1'b1);
    step("unhold5", 4'b0100, 4'b0000, 4'b0000, 1'b0);

    // 6. Reset while ch3 has counted to 2
    async_in = 4'b1100;
    for (int i = 1; i <= 4; i++) step("mid_cnt", 4'b0100, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b1;
    step("mid_rst", 4'b0101, 4'b0000, 4'b0000, 1'b0);
    rst = 1'b0;
    step("mid_rel1", 4'b0101, 4'b0000, 4'b0000, 1'b0);
    step("mid_rel2", 4'b0101, 4'b0000, 4'b0000, 1'b0);
    step("mid_rel3", 4'b0100, 4'b0000, 4'b0001, 1'b1);
    step("mid_rel4", 4'b0100, 4'b0000, 4'b0000, 1'b0);
    step("mid_rel5", 4'b0100, 4'b0000, 4'b0000, 1'b0);
    step("mid_rel6", 4'b1100, 4'b1000, 4'b0000, 1'b1);
    step("mid_rel7", 4'b1100, 4'b0000, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
